// File: rtl/diff_frame_detector.sv
// diff_frame_detector
// Takes the per-pixel XOR difference stream coming from the training memory
// bank in detect mode and produces one result record per frame. The record
// holds the changed-pixel count, the bounding box of the changed pixels and
// a detect flag. A pixel is "changed" when enough of its bits differ. The
// record is offered to the host over a valid/ready handshake.

module diff_frame_detector #(
   parameter int IMG_WIDTH  = 16,
   parameter int IMG_HEIGHT = 16,
   parameter int BIT_THRESH = 2,
   parameter int MIN_PIXELS = 4,
   localparam int XW = $clog2(IMG_WIDTH),
   localparam int YW = $clog2(IMG_HEIGHT)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_mode,
   input  logic [7:0]    i_diff_data,
   input  logic          i_diff_valid,
   output logic          o_busy,
   output logic          o_result_valid,
   input  logic          i_result_ready,
   output logic          o_detected,
   output logic [15:0]   o_pix_count,
   output logic [XW-1:0] o_min_x,
   output logic [XW-1:0] o_max_x,
   output logic [YW-1:0] o_min_y,
   output logic [YW-1:0] o_max_y,
   output logic          o_overrun
);

   localparam logic [XW-1:0] X_LAST      = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST      = YW'(IMG_HEIGHT - 1);
   localparam logic [3:0]    BIT_THRESH_L = 4'(BIT_THRESH);
   localparam logic [15:0]   MIN_PIX_L    = 16'(MIN_PIXELS);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   typedef struct packed {
      logic          det;
      logic [15:0]   cnt;
      logic [XW-1:0] min_x;
      logic [XW-1:0] max_x;
      logic [YW-1:0] min_y;
      logic [YW-1:0] max_y;
   } result_t;

   state_t state, state_nxt;

   // frame accumulators
   logic [XW-1:0] x_pos, min_x;
   logic [XW-1:0] max_x;
   logic [YW-1:0] y_pos, min_y;
   logic [YW-1:0] max_y;
   logic [15:0]   cnt;

   // updated accumulator values for the pixel in this cycle
   logic [15:0]   cnt_upd;
   logic [XW-1:0] min_x_upd, max_x_upd, x_nxt;
   logic [YW-1:0] min_y_upd, max_y_upd, y_nxt;

   logic          take_pix, pix_changed, pix_hit, last_pix, acc_clr;
   logic [3:0]    pop;
   result_t       res, res_nxt;
   logic          overrun;

   function automatic logic [3:0] popcnt8(input logic [7:0] d);
      logic [3:0] s;
      s = 4'd0;
      for (int i = 0; i < 8; i++) s = s + {3'b000, d[i]};
      return s;
   endfunction

   // Pixel acceptance and per-pixel evaluation, all within the strobe cycle.
   // A pixel is taken only in IDLE (as the first pixel of a frame) or ACCUM,
   // and only while detect mode is on; in REPORT it is dropped.
   always_comb begin
      pop         = popcnt8(i_diff_data);
      pix_changed = (pop >= BIT_THRESH_L);
      take_pix    = i_diff_valid && i_mode &&
                    ((state == S_IDLE) || (state == S_ACCUM));
      pix_hit     = take_pix && pix_changed;
      last_pix    = take_pix && (x_pos == X_LAST) && (y_pos == Y_LAST);
   end

   // Next accumulator values; the raster position wraps x then bumps y.
   always_comb begin
      cnt_upd   = cnt;
      min_x_upd = min_x;
      max_x_upd = max_x;
      min_y_upd = min_y;
      max_y_upd = max_y;
      if (pix_hit) begin
         if (cnt != 16'hFFFF) cnt_upd = cnt + 16'd1;
         if (x_pos < min_x) min_x_upd = x_pos;
         if (x_pos > max_x) max_x_upd = x_pos;
         if (y_pos < min_y) min_y_upd = y_pos;
         if (y_pos > max_y) max_y_upd = y_pos;
      end
      if (x_pos == X_LAST) begin
         x_nxt = '0;
         y_nxt = y_pos + 1'b1;
      end else begin
         x_nxt = x_pos + 1'b1;
         y_nxt = y_pos;
      end
   end

   // Result record as it will be frozen on entry to REPORT. An empty frame
   // reports a zero box rather than the inverted cleared bounds.
   always_comb begin
      res_nxt.det = (cnt_upd >= MIN_PIX_L);
      res_nxt.cnt = cnt_upd;
      if (cnt_upd == 16'd0) begin
         res_nxt.min_x = '0;
         res_nxt.max_x = '0;
         res_nxt.min_y = '0;
         res_nxt.max_y = '0;
      end else begin
         res_nxt.min_x = min_x_upd;
         res_nxt.max_x = max_x_upd;
         res_nxt.min_y = min_y_upd;
         res_nxt.max_y = max_y_upd;
      end
   end

   // Next-state logic; leaving ACCUM by abort or REPORT by handshake clears
   // the accumulators so the next frame starts clean.
   always_comb begin
      state_nxt = state;
      acc_clr   = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_diff_valid && i_mode) state_nxt = S_ACCUM;
         end
         S_ACCUM: begin
            if (!i_mode) begin
               state_nxt = S_IDLE;
               acc_clr   = 1'b1;
            end else if (last_pix) begin
               state_nxt = S_REPORT;
            end
         end
         S_REPORT: begin
            if (i_result_ready) begin
               state_nxt = S_IDLE;
               acc_clr   = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Accumulator registers: cleared on reset/abort/handshake, else advanced
   // by every accepted pixel.
   always_ff @(posedge i_clk) begin
      if (i_reset || acc_clr) begin
         x_pos <= '0;
         y_pos <= '0;
         cnt   <= 16'd0;
         min_x <= X_LAST;
         min_y <= Y_LAST;
         max_x <= '0;
         max_y <= '0;
      end else if (take_pix) begin
         x_pos <= x_nxt;
         y_pos <= y_nxt;
         cnt   <= cnt_upd;
         min_x <= min_x_upd;
         min_y <= min_y_upd;
         max_x <= max_x_upd;
         max_y <= max_y_upd;
      end
   end

   // Result record: captured with the last pixel, held until the next frame
   // completes so the outputs stay put after the handshake.
   always_ff @(posedge i_clk) begin
      if (i_reset)       res <= '0;
      else if (last_pix) res <= res_nxt;
   end

   // Sticky overrun: any strobe while a result is pending is lost.
   always_ff @(posedge i_clk) begin
      if (i_reset)                                  overrun <= 1'b0;
      else if (state == S_REPORT && i_diff_valid)   overrun <= 1'b1;
   end

   assign o_busy         = (state == S_ACCUM);
   assign o_result_valid = (state == S_REPORT);
   assign o_detected     = res.det;
   assign o_pix_count    = res.cnt;
   assign o_min_x        = res.min_x;
   assign o_max_x        = res.max_x;
   assign o_min_y        = res.min_y;
   assign o_max_y        = res.max_y;
   assign o_overrun      = overrun;

endmodule

// File: tb/tb_diff_frame_detector.sv
// Directed bench for diff_frame_detector on a 16x16 frame. Inputs change on
// the falling edge; outputs are checked on the falling edge after the
// rising edge that registered them.

module tb_diff_frame_detector;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_mode;
   logic [7:0] i_diff_data;
   logic       i_diff_valid;
   logic       o_busy, o_result_valid, i_result_ready, o_detected, o_overrun;
   logic [15:0] o_pix_count;
   logic [3:0] o_min_x, o_max_x, o_min_y, o_max_y;

   int checks = 0;
   int errors = 0;

   diff_frame_detector #(
      .IMG_WIDTH(16), .IMG_HEIGHT(16), .BIT_THRESH(2), .MIN_PIXELS(4)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_mode(i_mode),
      .i_diff_data(i_diff_data), .i_diff_valid(i_diff_valid),
      .o_busy(o_busy), .o_result_valid(o_result_valid),
      .i_result_ready(i_result_ready), .o_detected(o_detected),
      .o_pix_count(o_pix_count), .o_min_x(o_min_x), .o_max_x(o_max_x),
      .o_min_y(o_min_y), .o_max_y(o_max_y), .o_overrun(o_overrun)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic det, input int cnt,
                          input int mnx, input int mxx, input int mny, input int mxy);
      chk({tag, "_valid"}, 32'(o_result_valid), 32'd1);
      chk({tag, "_det"},   32'(o_detected), 32'(det));
      chk({tag, "_cnt"},   32'(o_pix_count), cnt);
      chk({tag, "_minx"},  32'(o_min_x), mnx);
      chk({tag, "_maxx"},  32'(o_max_x), mxx);
      chk({tag, "_miny"},  32'(o_min_y), mny);
      chk({tag, "_maxy"},  32'(o_max_y), mxy);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"},  32'(o_busy), 32'd0);
      chk({tag, "_valid"}, 32'(o_result_valid), 32'd0);
      chk({tag, "_det"},   32'(o_detected), 32'd0);
      chk({tag, "_ovr"},   32'(o_overrun), 32'd0);
      chk({tag, "_cnt"},   32'(o_pix_count), 32'd0);
      chk({tag, "_bbox"},  {16'd0, o_min_x, o_max_x, o_min_y, o_max_y}, 32'd0);
   endtask

   // Frame patterns: 0 empty, 1 block 12px, 2 three 8'h03, 3 four 8'h03,
   // 4 five 8'h03. Background of patterns 1-4 is 8'h01 (one bit, below threshold).
   function automatic logic [7:0] pix_val(input int kind, input int x, input int y);
      logic hit;
      case (kind)
         0: return 8'h00;
         1: return (x >= 3 && x <= 6 && y >= 2 && y <= 4) ? 8'hFF : 8'h01;
         2: hit = (x == 0 && y == 0) || (x == 15 && y == 15) || (x == 7 && y == 8);
         3: hit = (x == 1 || x == 2) && (y == 1 || y == 2);
         default: hit = (y == 4 && x >= 4 && x <= 6) || (x == 4 && y == 5) ||
                        (x == 9 && y == 10);
      endcase
      return hit ? 8'h03 : 8'h01;
   endfunction

   task automatic send_frame(input int kind, input int npix);
      for (int i = 0; i < npix; i++) begin
         i_diff_valid = 1'b1;
         i_diff_data  = pix_val(kind, i % 16, i / 16);
         @(negedge i_clk);
      end
      i_diff_valid = 1'b0;
      i_diff_data  = 8'h00;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1; i_mode = 1'b1; i_diff_data = 8'h00; i_diff_valid = 1'b0;
      i_result_ready = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      chk_reset_state("rst");

      // Empty frame
      send_frame(0, 256);
      chk_res("empty", 1'b0, 0, 0, 0, 0, 0);
      @(negedge i_clk);
      chk("empty_vfall", 32'(o_result_valid), 32'd0);
      chk("empty_idle",  32'(o_busy), 32'd0);

      // Block object
      send_frame(1, 256);
      chk_res("block", 1'b1, 12, 3, 6, 2, 4);
      @(negedge i_clk);

      // Threshold edges
      send_frame(2, 256);
      chk_res("three", 1'b0, 3, 0, 15, 0, 15);
      @(negedge i_clk);
      send_frame(3, 256);
      chk_res("four", 1'b1, 4, 1, 2, 1, 2);
      @(negedge i_clk);

      // Backpressure, overrun, mode drop during REPORT
      i_result_ready = 1'b0;
      send_frame(1, 256);
      chk_res("bp", 1'b1, 12, 3, 6, 2, 4);
      for (int c = 0; c < 10; c++) begin
         i_diff_valid = (c == 3);
         i_diff_data  = 8'hFF;
         i_mode       = !(c == 5 || c == 6);
         @(negedge i_clk);
         chk("bp_hold_valid", 32'(o_result_valid), 32'd1);
         chk("bp_hold_data", {o_detected, o_pix_count, o_min_x, o_max_x, o_min_y, o_max_y},
             {1'b1, 16'd12, 4'd3, 4'd6, 4'd2, 4'd4});
         chk("bp_ovr", 32'(o_overrun), (c >= 3) ? 32'd1 : 32'd0);
      end
      i_mode = 1'b1;
      i_result_ready = 1'b1;
      i_diff_valid = 1'b1;            // strobe in the handshake cycle: dropped
      i_diff_data  = 8'hFF;
      @(negedge i_clk);
      i_diff_valid = 1'b0;
      chk("bp_vfall", 32'(o_result_valid), 32'd0);
      chk("bp_nostart", 32'(o_busy), 32'd0);
      chk("bp_hold_cnt", 32'(o_pix_count), 32'd12);
      chk("bp_ovr_sticky", 32'(o_overrun), 32'd1);
      send_frame(3, 256);
      chk_res("after_bp", 1'b1, 4, 1, 2, 1, 2);
      @(negedge i_clk);

      // Abort after 100 pixels, then a fresh frame
      send_frame(1, 100);
      chk("abort_busy", 32'(o_busy), 32'd1);
      i_mode = 1'b0;
      i_diff_valid = 1'b1;
      i_diff_data  = 8'hFF;
      @(negedge i_clk);
      i_diff_valid = 1'b0;
      chk("abort_busy0", 32'(o_busy), 32'd0);
      @(negedge i_clk);
      chk("abort_nores", 32'(o_result_valid), 32'd0);
      i_mode = 1'b1;
      send_frame(4, 256);
      chk_res("post_abort", 1'b1, 5, 4, 9, 4, 10);
      @(negedge i_clk);

      // Reset during ACCUM (overrun is still set from backpressure step)
      send_frame(1, 50);
      do_reset();
      chk_reset_state("rst_accum");

      // Reset during REPORT with overrun set
      i_result_ready = 1'b0;
      send_frame(1, 256);
      i_diff_valid = 1'b1;
      @(negedge i_clk);
      i_diff_valid = 1'b0;
      chk("rpt_ovr", 32'(o_overrun), 32'd1);
      do_reset();
      chk_reset_state("rst_report");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
